// File: rtl/motoro3_line_param_sequencer.sv
// Line-parameter sequencer: per accepted request, drives the sine-length lookup step,
// then derives amplitude and slope = (slConst * amp) >> 8 with a serial shift-add multiplier.
module motoro3_line_param_sequencer (
    input  logic        clk,
    input  logic        nRst,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [7:0]  pwmLen,
    input  logic [7:0]  pwmMin,
    input  logic [3:0]  lcStep,
    output logic [3:0]  slStep,
    input  logic [15:0] slConst,
    output logic [7:0]  lcAmp,
    output logic [15:0] lcSlope,
    output logic        lcValid,
    output logic        busy,
    output logic        errRange
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MUL    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [3:0]  r_slStep;
    logic [7:0]  r_amp;
    logic        r_errRange;
    logic [23:0] r_mcand;
    logic [23:0] r_acc;
    logic [2:0]  r_cnt;
    logic [7:0]  r_lcAmp;
    logic [15:0] r_lcSlope;

    logic        w_accept;
    logic        w_last_bit;
    logic [23:0] w_partial;
    logic [23:0] w_acc_next;
    logic [7:0]  w_amp_in;
    logic        w_range_err;

    // Request-side arithmetic evaluated only for the accept edge.
    always_comb begin
        w_range_err = (pwmMin > pwmLen);
        w_amp_in    = w_range_err ? 8'd0 : (pwmLen - pwmMin);
    end

    // Multiplier datapath: one bit of amp per MUL cycle, LSB first.
    always_comb begin
        w_partial  = r_amp[r_cnt] ? r_mcand : '0;
        w_acc_next = r_acc + w_partial;
        w_last_bit = (r_cnt == 3'd7);
    end

    always_comb begin
        w_state_next = r_state;
        reqReady     = 1'b0;
        busy         = 1'b1;
        lcValid      = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                reqReady = 1'b1;
                busy     = 1'b0;
                w_accept = reqValid;
                if (reqValid) begin
                    w_state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                w_state_next = MUL;
            end
            MUL: begin
                if (w_last_bit) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                lcValid      = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_slStep   <= '0;
            r_amp      <= '0;
            r_errRange <= 1'b0;
            r_mcand    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_lcAmp    <= '0;
            r_lcSlope  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_slStep   <= lcStep;
                        r_amp      <= w_amp_in;
                        r_errRange <= w_range_err;
                    end
                end
                LOOKUP: begin
                    // slConst has had a full cycle to settle on the new step.
                    r_mcand <= {8'd0, slConst};
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end
                MUL: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= r_mcand << 1;
                    r_cnt   <= r_cnt + 3'd1;
                    if (w_last_bit) begin
                        r_lcAmp   <= r_amp;
                        r_lcSlope <= w_acc_next[23:8];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign slStep   = r_slStep;
    assign lcAmp    = r_lcAmp;
    assign lcSlope  = r_lcSlope;
    assign errRange = r_errRange;

endmodule

// File: tb/tb_motoro3_line_param_sequencer.sv
// Directed bench for motoro3_line_param_sequencer with a small table model of the sine-length lookup.
module tb_motoro3_line_param_sequencer;

    logic        clk;
    logic        nRst;
    logic        reqValid;
    logic        reqReady;
    logic [7:0]  pwmLen;
    logic [7:0]  pwmMin;
    logic [3:0]  lcStep;
    logic [3:0]  slStep;
    logic [15:0] slConst;
    logic [7:0]  lcAmp;
    logic [15:0] lcSlope;
    logic        lcValid;
    logic        busy;
    logic        errRange;

    int n_vec;
    int n_err;

    motoro3_line_param_sequencer dut (
        .clk      (clk),
        .nRst     (nRst),
        .reqValid (reqValid),
        .reqReady (reqReady),
        .pwmLen   (pwmLen),
        .pwmMin   (pwmMin),
        .lcStep   (lcStep),
        .slStep   (slStep),
        .slConst  (slConst),
        .lcAmp    (lcAmp),
        .lcSlope  (lcSlope),
        .lcValid  (lcValid),
        .busy     (busy),
        .errRange (errRange)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lookup stand-in: combinational function of slStep.
    always_comb begin
        case (slStep)
            4'd1:    slConst = 16'h0100;
            4'd3:    slConst = 16'h1000;
            4'd5:    slConst = 16'h1234;
            4'd15:   slConst = 16'hFFFF;
            default: slConst = 16'h0040;
        endcase
    end

    // Presents a request at a falling edge and returns 1 time unit after the accept edge E0.
    task automatic issue(input logic [7:0] len, input logic [7:0] mn, input logic [3:0] st);
        @(negedge clk);
        pwmLen   = len;
        pwmMin   = mn;
        lcStep   = st;
        reqValid = 1'b1;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        nRst = 1'b0;
        #1;
        n_vec++;
        if ({reqReady, busy, lcValid, errRange} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_ctrl: got rdy/busy/val/err=%b want 1000", {reqReady, busy, lcValid, errRange});
        end
        n_vec++;
        if ({slStep, lcAmp, lcSlope} !== 28'd0) begin
            n_err++;
            $display("FAIL reset_data: got step=%0d amp=%0d slope=%h want 0", slStep, lcAmp, lcSlope);
        end
        @(negedge clk);
        nRst = 1'b1;
    endtask

    // Runs one request and checks timing plus results at the lcValid cycle.
    task automatic test_calc(input string nm, input logic [7:0] len, input logic [7:0] mn,
                             input logic [3:0] st, input logic [7:0] exp_amp,
                             input logic [15:0] exp_slope, input logic exp_err);
        issue(len, mn, st);
        n_vec++;
        if (slStep !== st || busy !== 1'b1 || reqReady !== 1'b0) begin
            n_err++;
            $display("FAIL %s_accept: got step=%0d busy=%b rdy=%b want step=%0d busy=1 rdy=0", nm, slStep, busy, reqReady, st);
        end
        n_vec++;
        if (errRange !== exp_err) begin
            n_err++;
            $display("FAIL %s_err: got %b want %b", nm, errRange, exp_err);
        end
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (lcValid !== (k == 9)) begin
                n_vec++;
                n_err++;
                $display("FAIL %s_valid_timing: cycle %0d got lcValid=%b want %b", nm, k, lcValid, (k == 9));
            end
            if (k == 9) begin
                n_vec++;
                if (lcAmp !== exp_amp || lcSlope !== exp_slope) begin
                    n_err++;
                    $display("FAIL %s_result: got amp=%h slope=%h want amp=%h slope=%h", nm, lcAmp, lcSlope, exp_amp, exp_slope);
                end
            end
        end
        n_vec++;
        if (reqReady !== 1'b1 || busy !== 1'b0 || errRange !== exp_err || lcSlope !== exp_slope) begin
            n_err++;
            $display("FAIL %s_hold: got rdy=%b busy=%b err=%b slope=%h want 1 0 %b %h", nm, reqReady, busy, errRange, lcSlope, exp_err, exp_slope);
        end
    endtask

    task automatic test_back_to_back;
        int pulses;
        pulses = 0;
        @(negedge clk);
        pwmLen   = 8'd100;
        pwmMin   = 8'd20;
        lcStep   = 4'd1;
        reqValid = 1'b1;
        @(posedge clk);
        #1;
        // Second request presented immediately; must not disturb the first.
        pwmLen = 8'd50;
        pwmMin = 8'd10;
        lcStep = 4'd3;
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk);
            #1;
            if (lcValid === 1'b1) pulses++;
            if (k == 9) begin
                n_vec++;
                if (lcValid !== 1'b1 || lcAmp !== 8'd80 || lcSlope !== 16'h0050) begin
                    n_err++;
                    $display("FAIL b2b_first: got val=%b amp=%0d slope=%h want 1 80 0050", lcValid, lcAmp, lcSlope);
                end
            end
            if (k == 10) begin
                n_vec++;
                if (reqReady !== 1'b1 || slStep !== 4'd1) begin
                    n_err++;
                    $display("FAIL b2b_gap: got rdy=%b step=%0d want 1 1", reqReady, slStep);
                end
            end
            if (k == 11) begin
                reqValid = 1'b0;
                n_vec++;
                if (slStep !== 4'd3 || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_second_accept: got step=%0d busy=%b want 3 1", slStep, busy);
                end
                pwmLen = 8'd255;
                pwmMin = 8'd0;
                lcStep = 4'd15;
            end
            if (k == 20) begin
                n_vec++;
                if (lcValid !== 1'b1 || lcAmp !== 8'd40 || lcSlope !== 16'h0280) begin
                    n_err++;
                    $display("FAIL b2b_second: got val=%b amp=%0d slope=%h want 1 40 0280", lcValid, lcAmp, lcSlope);
                end
            end
        end
        n_vec++;
        if (pulses !== 2) begin
            n_err++;
            $display("FAIL b2b_pulses: got %0d want 2", pulses);
        end
    endtask

    task automatic test_reset_mid_mul;
        int pulses;
        pulses = 0;
        issue(8'd200, 8'd40, 4'd3);
        repeat (5) @(posedge clk);
        #1;
        nRst = 1'b0;
        #1;
        n_vec++;
        if ({reqReady, busy, lcValid, errRange, slStep, lcAmp, lcSlope} !== {4'b1000, 28'd0}) begin
            n_err++;
            $display("FAIL midmul_reset: got rdy=%b busy=%b val=%b err=%b step=%0d amp=%h slope=%h want 1 0 0 0 0 0 0",
                     reqReady, busy, lcValid, errRange, slStep, lcAmp, lcSlope);
        end
        @(negedge clk);
        nRst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (lcValid === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses !== 0 || lcSlope !== 16'd0 || lcAmp !== 8'd0) begin
            n_err++;
            $display("FAIL midmul_dropped: got pulses=%0d amp=%h slope=%h want 0 0 0", pulses, lcAmp, lcSlope);
        end
        test_calc("post_reset", 8'd100, 8'd0, 4'd1, 8'd100, 16'd100, 1'b0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        nRst     = 1'b0;
        reqValid = 1'b0;
        pwmLen   = 8'd0;
        pwmMin   = 8'd0;
        lcStep   = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nRst = 1'b1;
        repeat (2) @(posedge clk);

        test_reset();
        test_calc("nominal", 8'd200, 8'd40, 4'd3, 8'hA0, 16'h0A00, 1'b0);
        test_calc("range", 8'd10, 8'd50, 4'd5, 8'h00, 16'h0000, 1'b1);
        test_calc("maximum", 8'd255, 8'd0, 4'd15, 8'hFF, 16'hFEFF, 1'b0);
        test_back_to_back();
        test_reset_mid_mul();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
